// File: rtl/ff_pkg.sv
// Edge-select encodings and the width helper shared by the edge counter slice.
package ff_pkg;

   localparam logic [1:0] EDGE_NONE = 2'b00;
   localparam logic [1:0] EDGE_RISE = 2'b01;
   localparam logic [1:0] EDGE_FALL = 2'b10;
   localparam logic [1:0] EDGE_BOTH = 2'b11;

   // Bits needed to hold values 0..value-1; bounded loop keeps it elaboration-friendly.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/ff_debounce.sv
// Debounce filter for a synchronous bit plus one-cycle rise/fall pulses.
// Filtered level and pulses update on the edge that completes STABLE_CYCLES of agreement.
module ff_debounce
   import ff_pkg::*;
#(
   parameter int   STABLE_CYCLES = 4,
   parameter logic IDLE_VAL      = 1'b0
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic data_i,
   output logic data_filt_o,
   output logic rise_o,
   output logic fall_o,
   output logic rise_nxt_o,
   output logic fall_nxt_o
);

   localparam int SW_RAW = clog2(STABLE_CYCLES + 1);
   localparam int SW     = (SW_RAW < 1) ? 1 : SW_RAW;
   localparam logic [SW-1:0] LAST = SW'(STABLE_CYCLES - 1);

   logic [SW-1:0] r_cnt;
   logic          r_filt;
   logic          r_rise;
   logic          r_fall;

   logic          w_diff;
   logic          w_accept;

   assign w_diff   = (data_i != r_filt);
   assign w_accept = w_diff && (r_cnt == LAST);

   // Exposed so the counter can commit in the same edge that raises the pulse.
   assign rise_nxt_o = w_accept &  data_i;
   assign fall_nxt_o = w_accept & ~data_i;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_filt <= IDLE_VAL;
         r_cnt  <= '0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= rise_nxt_o;
         r_fall <= fall_nxt_o;
         if (w_accept) begin
            r_filt <= data_i;
            r_cnt  <= '0;
         end else if (w_diff) begin
            r_cnt  <= r_cnt + SW'(1);
         end else begin
            r_cnt  <= '0;
         end
      end
   end

   assign data_filt_o = r_filt;
   assign rise_o      = r_rise;
   assign fall_o      = r_fall;

endmodule

// File: rtl/ff_edge_counter.sv
// Debounced edge monitor: filtered level, rise/fall pulses and a saturating selected-edge count.
// Count and sticky overflow update on the same edge as the pulse; clear beats a same-cycle edge.
module ff_edge_counter
   import ff_pkg::*;
#(
   parameter int   STABLE_CYCLES = 4,
   parameter int   CNT_W         = 8,
   parameter logic IDLE_VAL      = 1'b0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             data_i,
   input  logic             enable_i,
   input  logic [1:0]       edge_sel_i,
   input  logic             clear_i,
   output logic             data_filt_o,
   output logic             rise_o,
   output logic             fall_o,
   output logic [CNT_W-1:0] count_o,
   output logic             ovf_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             w_rise_nxt;
   logic             w_fall_nxt;
   logic             w_sel_rise;
   logic             w_sel_fall;
   logic             w_hit;

   logic [CNT_W-1:0] r_count;
   logic             r_ovf;

   ff_debounce #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .IDLE_VAL      (IDLE_VAL)
   ) u_debounce (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .data_i      (data_i),
      .data_filt_o (data_filt_o),
      .rise_o      (rise_o),
      .fall_o      (fall_o),
      .rise_nxt_o  (w_rise_nxt),
      .fall_nxt_o  (w_fall_nxt)
   );

   assign w_sel_rise = enable_i && w_rise_nxt &&
                       ((edge_sel_i == EDGE_RISE) || (edge_sel_i == EDGE_BOTH));
   assign w_sel_fall = enable_i && w_fall_nxt &&
                       ((edge_sel_i == EDGE_FALL) || (edge_sel_i == EDGE_BOTH));
   assign w_hit      = w_sel_rise || w_sel_fall;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (clear_i) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (w_hit) begin
         if (r_count == CNT_MAX) begin
            r_ovf   <= 1'b1;
         end else begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign count_o = r_count;
   assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_ff_edge_counter.sv
// Directed bench: default build, a 2-bit-counter build and an S=1 build share one stimulus stream.
module tb_ff_edge_counter;
   import ff_pkg::*;

   logic       clk = 1'b0;
   logic       reset_i = 1'b1;
   logic       data_i = 1'b1;
   logic       enable_i = 1'b1;
   logic [1:0] edge_sel_i = EDGE_RISE;
   logic       clear_i = 1'b0;

   logic       filt_a, rise_a, fall_a, ovf_a;
   logic [7:0] count_a;
   logic       filt_b, rise_b, fall_b, ovf_b;
   logic [1:0] count_b;
   logic       filt_c, rise_c, fall_c, ovf_c;
   logic [7:0] count_c;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ff_edge_counter #(.STABLE_CYCLES(4), .CNT_W(8), .IDLE_VAL(1'b0)) u_dut (
      .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .enable_i(enable_i),
      .edge_sel_i(edge_sel_i), .clear_i(clear_i), .data_filt_o(filt_a),
      .rise_o(rise_a), .fall_o(fall_a), .count_o(count_a), .ovf_o(ovf_a));

   ff_edge_counter #(.STABLE_CYCLES(4), .CNT_W(2), .IDLE_VAL(1'b0)) u_sat (
      .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .enable_i(enable_i),
      .edge_sel_i(edge_sel_i), .clear_i(clear_i), .data_filt_o(filt_b),
      .rise_o(rise_b), .fall_o(fall_b), .count_o(count_b), .ovf_o(ovf_b));

   ff_edge_counter #(.STABLE_CYCLES(1), .CNT_W(8), .IDLE_VAL(1'b0)) u_s1 (
      .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .enable_i(enable_i),
      .edge_sel_i(edge_sel_i), .clear_i(clear_i), .data_filt_o(filt_c),
      .rise_o(rise_c), .fall_o(fall_c), .count_o(count_c), .ovf_o(ovf_c));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold data_i at v for 4 edges; the level and a pulse must appear only after the 4th.
   task automatic hold4(input logic v, input string tag);
      data_i = v;
      for (int i = 0; i < 3; i++) begin
         step();
         check({tag, "_wait_filt"}, filt_a, !v);
      end
      step();
      check({tag, "_filt"}, filt_a, v);
      check({tag, "_pulse"}, v ? rise_a : fall_a, 1);
      check({tag, "_other_pulse"}, v ? fall_a : rise_a, 0);
      step();
      check({tag, "_pulse_gone"}, rise_a | fall_a, 0);
   endtask

   task automatic pulse_clear();
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
   endtask

   initial begin
      // 1: reset held with data_i=1
      for (int i = 0; i < 3; i++) step();
      check("rst_filt", filt_a, 0);
      check("rst_rise", rise_a, 0);
      check("rst_fall", fall_a, 0);
      check("rst_count", count_a, 0);
      check("rst_ovf", ovf_a, 0);
      check("rst_s1_filt", filt_c, 0);

      // 2: release; data_i already 1, accepted after the 4th edge
      reset_i = 1'b0;
      step();
      check("s1_filt_delay", filt_c, 1);
      check("s1_rise", rise_c, 1);
      check("lat_e1_filt", filt_a, 0);
      step();
      check("lat_e2_filt", filt_a, 0);
      step();
      check("lat_e3_filt", filt_a, 0);
      check("lat_e3_count", count_a, 0);
      step();
      check("lat_e4_filt", filt_a, 1);
      check("lat_e4_rise", rise_a, 1);
      check("lat_e4_count", count_a, 1);
      step();
      check("lat_rise_1cyc", rise_a, 0);
      check("s1_rise_1cyc", rise_c, 0);

      // 3: back to 0 (fall not selected), then a 3-cycle glitch high
      hold4(1'b0, "fall0");
      check("fall_not_counted", count_a, 1);
      data_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("glitch_rise", rise_a, 0);
      end
      data_i = 1'b0;
      step();
      check("glitch_filt", filt_a, 0);
      check("glitch_rise_after", rise_a, 0);
      check("glitch_count", count_a, 1);
      step();
      check("glitch_no_late_rise", rise_a, 0);

      // 4: edge select variants over 3 full toggles
      pulse_clear();
      check("clr_count", count_a, 0);
      edge_sel_i = EDGE_BOTH;
      for (int t = 0; t < 3; t++) begin
         hold4(1'b1, "both_r");
         hold4(1'b0, "both_f");
      end
      check("both_count", count_a, 6);
      check("sat_both_count", count_b, 3);
      check("sat_both_ovf", ovf_b, 1);

      pulse_clear();
      edge_sel_i = EDGE_FALL;
      for (int t = 0; t < 3; t++) begin
         hold4(1'b1, "fsel_r");
         hold4(1'b0, "fsel_f");
      end
      check("fall_count", count_a, 3);

      pulse_clear();
      edge_sel_i = EDGE_BOTH;
      enable_i = 1'b0;
      for (int t = 0; t < 3; t++) begin
         hold4(1'b1, "dis_r");
         hold4(1'b0, "dis_f");
      end
      check("disabled_count", count_a, 0);
      enable_i = 1'b1;

      // 5: saturation on the 2-bit build, rising edges only
      pulse_clear();
      check("sat_clr_ovf", ovf_b, 0);
      edge_sel_i = EDGE_RISE;
      for (int t = 1; t <= 5; t++) begin
         hold4(1'b1, "sat_r");
         hold4(1'b0, "sat_f");
         check("sat_count", count_b, (t >= 3) ? 3 : t);
         check("sat_ovf", ovf_b, (t >= 4) ? 1 : 0);
      end
      check("sat_wide_count", count_a, 5);
      pulse_clear();
      check("sat_after_clr_count", count_b, 0);
      check("sat_after_clr_ovf", ovf_b, 0);

      // 6a: clear in the same cycle as a counted rise
      hold4(1'b1, "pre_r");
      hold4(1'b0, "pre_f");
      check("pre_clr_count", count_a, 1);
      data_i = 1'b1;
      for (int i = 0; i < 3; i++) step();
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      check("clr_edge_rise", rise_a, 1);
      check("clr_edge_count", count_a, 0);
      step();
      check("clr_edge_count_hold", count_a, 0);

      // 6b: reset with the stable counter at 2 aborts the pending transition
      hold4(1'b0, "pre_rst_f");
      data_i = 1'b1;
      step();
      step();
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      check("midrst_filt", filt_a, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("midrst_wait", filt_a, 0);
      end
      step();
      check("midrst_filt_after4", filt_a, 1);
      check("midrst_rise", rise_a, 1);
      check("midrst_count", count_a, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
